// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the CPU device bus.
//
// Ports
//   Clk    system clock, all state changes on the rising edge
//   Reset  synchronous active-high reset
//   A      CPU word address [12:2]
//   WD     CPU store data
//   WE     CPU store strobe (full-word writes only)
//   RD     combinational read data for the addressed register
//   IRQ    interrupt request (flag AND IM, both registered)
//
// Register map (word offset from BASE_WORD)
//   0 CTRL   {IM, Mode[1:0], Enable}; upper bits read 0
//   1 PRESET reload value
//   2 COUNT  current count, read-only
module timer_dev #(
  parameter logic [10:0] BASE_WORD = 11'd1984
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  localparam logic [10:0] ADDR_CTRL   = BASE_WORD;
  localparam logic [10:0] ADDR_PRESET = BASE_WORD + 11'd1;
  localparam logic [10:0] ADDR_COUNT  = BASE_WORD + 11'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic wr_ctrl, wr_preset;
  logic auto_reload;

  assign wr_ctrl     = WE && (A == ADDR_CTRL);
  assign wr_preset   = WE && (A == ADDR_PRESET);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        // Clearing here turns the auto-reload flag into a one-cycle pulse.
        flag_d  = 1'b0;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Also covers PRESET = 0: one CNT cycle, then INT.
          count_d = '0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        flag_d = 1'b1;
        if (auto_reload) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes are applied last so they override the FSM's own updates
    // (Enable clear and flag set in INT). The state transition is unchanged.
    if (wr_ctrl) begin
      ctrl_d = WD[3:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = WD;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    RD = '0;
    if (A == ADDR_CTRL)        RD = {28'd0, ctrl_q};
    else if (A == ADDR_PRESET) RD = preset_q;
    else if (A == ADDR_COUNT)  RD = count_q;
  end

  assign IRQ = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized and directed checks of timer_dev against a
// closed-form timeline model (count / irq / enable as a function of the
// number of cycles since Enable was written).
module tb_timer_dev;

  localparam logic [10:0] BASE = 11'd1984;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [10:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_dev #(.BASE_WORD(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .WD(WD), .WE(WE), .RD(RD), .IRQ(IRQ)
  );

  always #5 Clk = ~Clk;

  // ---------------- bus helpers (inputs change 1ns after the edge) --------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    @(posedge Clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  task automatic do_reset();
    Reset = 1'b1; WE = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  // ---------------- reference model ---------------------------------------
  // k = number of edges since the edge that wrote Enable=1 (k=0 right after it).
  function automatic int unsigned eff(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [31:0] ref_count(input int unsigned n, input bit auto_m,
                                            input int k, input logic [31:0] c0);
    int unsigned j;
    if (k < 2) return c0;
    j = k - 2;
    if (auto_m) j = j % (eff(n) + 2);
    else if (j > eff(n)) j = eff(n);
    return (n > j) ? n - j : 0;
  endfunction

  function automatic bit ref_flag(input int unsigned n, input bit auto_m, input int k);
    if (k < 3) return 1'b0;
    if (auto_m) return ((k - 2) % (eff(n) + 2)) == eff(n) + 1;
    return k >= 3 + eff(n);
  endfunction

  function automatic bit ref_en(input int unsigned n, input bit auto_m, input int k);
    if (auto_m) return 1'b1;
    return k < 3 + eff(n);
  endfunction

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    Reset = 1'b1; WE = 1'b0; A = '0; WD = '0;
    tick(); tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 11'(i), d);
      checks++;
      if (d !== 32'd0) begin
        errors++; $display("FAIL reset_reg%0d got %h want 0", i, d);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", IRQ); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd1, 32'd5);
    wr(BASE, 32'h9);
    for (int k = 0; k <= 9; k++) begin
      rd(BASE + 11'd2, d);
      if (k == 2) begin
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL oneshot_e2 count %0d want 5", d); end
      end
      if (k == 6) begin
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL oneshot_e6 count %0d want 1", d); end
      end
      if (k == 7) begin
        checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin
          errors++; $display("FAIL oneshot_e7 count %0d irq %b want 0/0", d, IRQ);
        end
      end
      if (k >= 8) begin
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq k=%0d got %b want 1", k, IRQ); end
        rd(BASE, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl got %h want 8", d); end
      end
      tick();
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int rises[$];
    int high_cycles = 0;
    logic prev = 1'b0;
    logic [31:0] exp_seq [6] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
    do_reset();
    wr(BASE + 11'd1, 32'd3);
    wr(BASE, 32'hB);
    for (int k = 0; k < 25; k++) begin
      rd(BASE + 11'd2, d);
      if (k >= 2 && k <= 7) begin
        checks++;
        if (d !== exp_seq[k-2]) begin
          errors++; $display("FAIL auto_seq k=%0d count %0d want %0d", k, d, exp_seq[k-2]);
        end
      end
      if (IRQ === 1'b1) high_cycles++;
      if (IRQ === 1'b1 && prev !== 1'b1) rises.push_back(k);
      prev = IRQ;
      tick();
    end
    checks++;
    if (rises.size() != 4 || high_cycles != 4) begin
      errors++; $display("FAIL auto_pulses rises %0d high %0d want 4/4", rises.size(), high_cycles);
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 5) begin
        errors++; $display("FAIL auto_period got %0d want 5", rises[i] - rises[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int unsigned n;
    logic [1:0] mode;
    logic im;
    bit am;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      n    = $urandom_range(0, 9);
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      am   = (mode == 2'b01);
      wr(BASE + 11'd1, n);
      wr(BASE, {28'd0, im, mode, 1'b1});
      for (int k = 0; k < 3 * (int'(eff(n)) + 2) + 3; k++) begin
        rd(BASE + 11'd2, d);
        checks++;
        if (d !== ref_count(n, am, k, 32'd0)) begin
          errors++;
          $display("FAIL rand_count it=%0d n=%0d mode=%0d k=%0d got %0d want %0d",
                   it, n, mode, k, d, ref_count(n, am, k, 32'd0));
        end
        checks++;
        if (IRQ !== (im & ref_flag(n, am, k))) begin
          errors++;
          $display("FAIL rand_irq it=%0d n=%0d mode=%0d im=%0d k=%0d got %b want %b",
                   it, n, mode, im, k, IRQ, im & ref_flag(n, am, k));
        end
        rd(BASE, d);
        checks++;
        if (d !== {28'd0, im, mode, ref_en(n, am, k)}) begin
          errors++;
          $display("FAIL rand_ctrl it=%0d k=%0d got %h want %h", it, k, d,
                   {28'd0, im, mode, ref_en(n, am, k)});
        end
        tick();
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] d;
    int guard = 0;
    do_reset();
    wr(BASE + 11'd1, 32'd100);
    wr(BASE, 32'h9);
    rd(BASE + 11'd2, d);
    while (d !== 32'd60 && guard < 200) begin
      tick(); guard++;
      rd(BASE + 11'd2, d);
    end
    checks++;
    if (d !== 32'd60) begin
      errors++; $display("FAIL halt_reach60 timeout count %0d want 60", d);
    end
    wr(BASE, 32'h8);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 11'd2, d);
      checks++;
      if (d !== 32'd59 || IRQ !== 1'b0) begin
        errors++; $display("FAIL halt_freeze i=%0d count %0d irq %b want 59/0", i, d, IRQ);
      end
      tick();
    end
    wr(BASE, 32'h9);
    tick(); tick();
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd100) begin errors++; $display("FAIL halt_restart count %0d want 100", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd1, 32'd2);
    wr(BASE, 32'h1);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_im0 k=%0d irq %b want 0", k, IRQ); end
      tick();
    end
    wr(BASE, 32'h9);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL mask_im1 irq %b want 1", IRQ); end
    wr(BASE, 32'h8);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_clear irq %b want 0", IRQ); end
    tick();
    rd(BASE, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'h8) begin
      errors++; $display("FAIL mask_clear_hold irq %b ctrl %h want 0/8", IRQ, d);
    end
  endtask

  task automatic test_ctrl_at_int();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd1, 32'd2);
    wr(BASE, 32'h9);
    for (int k = 0; k < 4; k++) tick();
    wr(BASE, 32'h9);  // lands on the INT-state edge
    rd(BASE, d);
    checks++;
    if (d !== 32'h9 || IRQ !== 1'b0) begin
      errors++; $display("FAIL int_ctrl_win ctrl %h irq %b want 9/0", d, IRQ);
    end
    tick();
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL int_ctrl_noflag irq %b want 0", IRQ); end
    tick();
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL int_ctrl_reload count %0d want 2", d); end
  endtask

  task automatic test_preset_cnt();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd1, 32'd10);
    wr(BASE, 32'h9);
    for (int k = 0; k < 4; k++) tick();
    wr(BASE + 11'd1, 32'd3);  // now k = 5
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL preset_cnt count %0d want 7", d); end
    for (int k = 5; k < 13; k++) tick();
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd0 || IRQ !== 1'b1) begin
      errors++; $display("FAIL preset_cnt_done count %0d irq %b want 0/1", d, IRQ);
    end
    wr(BASE, 32'h9);
    tick(); tick();
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL preset_next_load count %0d want 3", d); end
  endtask

  task automatic test_addr();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd2, 32'hFFFF_FFFF);
    rd(BASE + 11'd2, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL addr_count_ro got %h want 0", d); end
    wr(BASE + 11'd3, 32'hFFFF_FFFF);
    rd(BASE + 11'd3, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL addr_base3 got %h want 0", d); end
    rd(BASE - 11'd1, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL addr_below got %h want 0", d); end
    rd(BASE, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL addr_ctrl_untouched got %h want 0", d); end
    wr(BASE + 11'd1, 32'h1234);
    wr(BASE, 32'h8);
    Reset = 1'b1; A = BASE + 11'd1; WD = 32'hABCD; WE = 1'b1;
    tick();
    Reset = 1'b0; WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 11'(i), d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL addr_reset_we reg%0d got %h want 0", i, d); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    wr(BASE + 11'd1, 32'd20);
    wr(BASE, 32'h9);
    for (int k = 0; k < 5; k++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      rd(BASE + 11'd2, d);
      checks++;
      if (IRQ !== 1'b0 || d !== 32'd0) begin
        errors++; $display("FAIL reset_mid k=%0d irq %b count %0d want 0/0", k, IRQ, d);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_random();
    test_halt();
    test_mask();
    test_ctrl_at_int();
    test_preset_cnt();
    test_addr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
